// File: rtl/mp64_clkgate_ctrl.sv
// mp64_clkgate_ctrl: multi-channel clock-gating controller.
// Each channel runs an auto-idle / wake-handshake FSM whose enable drives a
// latch-based glitch-free gate cell. Software force-on beats force-off, and
// force-off beats all automatic behaviour.
`timescale 1ns/1ps

module mp64_clkgate (
  input  logic i_clk,
  input  logic i_en,
  input  logic i_test_en,
  output logic o_clk
);

  logic r_en_lat;

  // Enable latch is transparent only while the clock is low, so a change in
  // enable can never shorten a high phase already in progress.
  always_latch begin
    if (!i_clk) r_en_lat <= i_en | i_test_en;
  end

  assign o_clk = i_clk & r_en_lat;

endmodule

module mp64_clkgate_ctrl #(
  parameter int NCH      = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_en,
  input  logic [IDLE_W-1:0] cfg_idle_thresh,
  input  logic [NCH-1:0]    ch_busy,
  input  logic [NCH-1:0]    ch_wake_req,
  output logic [NCH-1:0]    ch_wake_ack,
  input  logic [NCH-1:0]    sw_force_on,
  input  logic [NCH-1:0]    sw_force_off,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    ch_enable,
  output logic [NCH-1:0]    ch_gated,
  output logic              all_gated
);

  localparam int                 WCNT_W  = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [WCNT_W-1:0]  WLAST   = WCNT_W'(WAKE_CYC - 1);
  localparam logic [IDLE_W-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_IDLE  = 2'd1,
    S_GATED = 2'd2,
    S_WAKE  = 2'd3
  } state_t;

  logic [NCH-1:0] w_foff;
  logic [NCH-1:0] w_act;
  logic           w_thr_zero;

  // Force-on masks force-off; force-on alone counts as activity.
  assign w_foff     = sw_force_off & ~sw_force_on;
  assign w_act      = ch_busy | ch_wake_req | sw_force_on;
  assign w_thr_zero = (cfg_idle_thresh == '0);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_t            r_state, w_state_nxt;
    logic [IDLE_W-1:0] r_cnt, w_cnt_nxt;
    logic [WCNT_W-1:0] r_wcnt, w_wcnt_nxt;

    // State and counter registers; reset returns the channel to RUN.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_RUN;
        r_cnt   <= '0;
        r_wcnt  <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_wcnt  <= w_wcnt_nxt;
      end
    end

    // Next-state logic. A zero threshold blocks new IDLE entries and also
    // keeps an in-progress IDLE from gating, while the count keeps running.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_wcnt_nxt  = r_wcnt;
      case (r_state)
        S_RUN: begin
          if (w_foff[g]) begin
            w_state_nxt = S_GATED;
          end else if (!w_act[g] && !w_thr_zero) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = IDLE_W'(1);
          end
        end
        S_IDLE: begin
          if (w_foff[g]) begin
            w_state_nxt = S_GATED;
          end else if (w_act[g]) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else if (!w_thr_zero && (r_cnt >= cfg_idle_thresh)) begin
            w_state_nxt = S_GATED;
          end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt   = r_cnt + IDLE_W'(1);
          end
        end
        S_GATED: begin
          if (!w_foff[g] && w_act[g]) begin
            w_state_nxt = S_WAKE;
            w_wcnt_nxt  = '0;
            w_cnt_nxt   = '0;
          end
        end
        S_WAKE: begin
          if (w_foff[g]) begin
            w_state_nxt = S_GATED;
          end else if (r_wcnt == WLAST) begin
            w_state_nxt = S_RUN;
          end else begin
            w_wcnt_nxt  = r_wcnt + WCNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_RUN;
        end
      endcase
    end

    assign ch_enable[g]   = (r_state != S_GATED);
    assign ch_gated[g]    = (r_state == S_GATED);
    assign ch_wake_ack[g] = (r_state == S_RUN) & ch_wake_req[g];

    mp64_clkgate u_gate (
      .i_clk     (clk),
      .i_en      (ch_enable[g]),
      .i_test_en (test_en),
      .o_clk     (clk_out[g])
    );
  end

  assign all_gated = &ch_gated;

endmodule

// File: tb/tb_mp64_clkgate_ctrl.sv
// Bench for mp64_clkgate_ctrl: per-cycle vector table plus hand sequences
// for edge counting, test override and reset during WAKE.
`timescale 1ns/1ps

module tb_mp64_clkgate_ctrl;

  localparam int NCH      = 4;
  localparam int IDLE_W   = 8;
  localparam int WAKE_CYC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              test_en;
  logic [IDLE_W-1:0] thresh;
  logic [NCH-1:0]    busy, req, fon, foff;
  logic [NCH-1:0]    ack, clk_out, en, gated;
  logic              all_g;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mp64_clkgate_ctrl #(.NCH(NCH), .IDLE_W(IDLE_W), .WAKE_CYC(WAKE_CYC)) dut (
    .clk             (clk),
    .rst             (rst),
    .test_en         (test_en),
    .cfg_idle_thresh (thresh),
    .ch_busy         (busy),
    .ch_wake_req     (req),
    .ch_wake_ack     (ack),
    .sw_force_on     (fon),
    .sw_force_off    (foff),
    .clk_out         (clk_out),
    .ch_enable       (en),
    .ch_gated        (gated),
    .all_gated       (all_g)
  );

  // Gated-clock monitor: rising-edge counts and high-pulse width check.
  logic [NCH-1:0] prev_co = '0;
  realtime        rise_t[NCH];
  int             edges[NCH];
  int             short_pulses = 0;

  always @(clk_out) begin
    for (int i = 0; i < NCH; i++) begin
      if (clk_out[i] === 1'b1 && prev_co[i] === 1'b0) begin
        edges[i]++;
        rise_t[i] = $realtime;
      end else if (clk_out[i] === 1'b0 && prev_co[i] === 1'b1) begin
        if ($realtime - rise_t[i] < 4.5) short_pulses++;
      end
    end
    prev_co = clk_out;
  end

  typedef struct packed {
    logic              rst;
    logic [IDLE_W-1:0] thr;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    fon;
    logic [NCH-1:0]    foff;
    logic [NCH-1:0]    e_en;
    logic [NCH-1:0]    e_gated;
    logic [NCH-1:0]    e_ack;
  } vec_t;

  vec_t tbl[$];
  int   snap1[NCH];
  int   snap2[NCH];

  function automatic vec_t mk(input logic r, input logic [IDLE_W-1:0] t,
                              input logic [NCH-1:0] b, input logic [NCH-1:0] rq,
                              input logic [NCH-1:0] fn, input logic [NCH-1:0] ff,
                              input logic [NCH-1:0] ee, input logic [NCH-1:0] eg,
                              input logic [NCH-1:0] ea);
    vec_t x;
    x.rst = r; x.thr = t; x.busy = b; x.req = rq; x.fon = fn; x.foff = ff;
    x.e_en = ee; x.e_gated = eg; x.e_ack = ea;
    return x;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  // Advance n active edges and settle 2 ns later, away from the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic take_snap(output int s[NCH]);
    for (int i = 0; i < NCH; i++) s[i] = edges[i];
  endtask

  initial begin
    rst = 1'b1; test_en = 1'b0; thresh = 8'd4;
    busy = '1; req = '0; fon = '0; foff = '0;

    //       rst thr  busy    req     fon     foff    en      gated   ack
    tbl.push_back(mk(1, 4, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 0 reset
    tbl.push_back(mk(1, 4, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 1 reset
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 2 IDLE1
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 3 IDLE2
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 4 IDLE3
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 5 IDLE4
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hE, 4'h1, 4'h0)); // 6 GATED
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hE, 4'h1, 4'h0)); // 7 GATED
    tbl.push_back(mk(0, 4, 4'hE, 4'h1, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 8 WAKE
    tbl.push_back(mk(0, 4, 4'hE, 4'h1, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 9 WAKE
    tbl.push_back(mk(0, 4, 4'hE, 4'h1, 4'h0, 4'h0, 4'hF, 4'h0, 4'h1)); // 10 RUN ack
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 11 IDLE1
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 12 IDLE2
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 13 IDLE3
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 14 RUN
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 15 IDLE1
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 16 IDLE2
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 17 IDLE3
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 18 IDLE4
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hE, 4'h1, 4'h0)); // 19 GATED
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 20 WAKE
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 21 WAKE
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 22 RUN
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 23 IDLE1
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 24 IDLE2
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 25 IDLE3
    tbl.push_back(mk(0, 2, 4'hE, 4'h0, 4'h0, 4'h0, 4'hE, 4'h1, 4'h0)); // 26 thr lowered
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 27 WAKE
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 28 WAKE
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 29 RUN
    tbl.push_back(mk(0, 4, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 30 IDLE1
    tbl.push_back(mk(0, 0, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 31 thr0 IDLE2
    tbl.push_back(mk(0, 0, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 32 thr0 IDLE3
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 33 RUN
    tbl.push_back(mk(0, 0, 4'hE, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 34 thr0 RUN
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h0, 4'h2, 4'hD, 4'h2, 4'h0)); // 35 foff ch1
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h2, 4'h2, 4'hF, 4'h0, 4'h0)); // 36 fon+foff WAKE
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h2, 4'h2, 4'hF, 4'h0, 4'h0)); // 37 WAKE
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h2, 4'h2, 4'hF, 4'h0, 4'h0)); // 38 RUN
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h2, 4'h0, 4'hF, 4'h0, 4'h0)); // 39 RUN
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h0, 4'h2, 4'hD, 4'h2, 4'h0)); // 40 GATED
    tbl.push_back(mk(0, 4, 4'hF, 4'h2, 4'h0, 4'h2, 4'hD, 4'h2, 4'h0)); // 41 foff beats req
    tbl.push_back(mk(0, 4, 4'hF, 4'h2, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 42 WAKE
    tbl.push_back(mk(0, 4, 4'hF, 4'h2, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 43 WAKE
    tbl.push_back(mk(0, 4, 4'hF, 4'h2, 4'h0, 4'h0, 4'hF, 4'h0, 4'h2)); // 44 RUN ack
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 45 req dropped
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h0, 4'h2, 4'hD, 4'h2, 4'h0)); // 46 GATED
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 47 WAKE
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h0, 4'h2, 4'hD, 4'h2, 4'h0)); // 48 foff in WAKE
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 49 WAKE
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 50 WAKE
    tbl.push_back(mk(0, 4, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0)); // 51 RUN
    tbl.push_back(mk(0, 4, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0)); // 52 all GATED

    cyc(1);
    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].rst; thresh = tbl[k].thr; busy = tbl[k].busy;
      req = tbl[k].req; fon = tbl[k].fon; foff = tbl[k].foff;
      cyc(1);
      chk("enable",    k, 16'(en),    16'(tbl[k].e_en));
      chk("gated",     k, 16'(gated), 16'(tbl[k].e_gated));
      chk("ack",       k, 16'(ack),   16'(tbl[k].e_ack));
      chk("all_gated", k, 16'(all_g), 16'(&tbl[k].e_gated));
    end

    // All gated, no override: no edges in 100 ns.
    take_snap(snap1); cyc(10);
    for (int i = 0; i < NCH; i++) chk("gated_edges", i, 16'(edges[i] - snap1[i]), 16'd0);

    // Test override: clocks run while FSMs stay gated.
    test_en = 1'b1;
    take_snap(snap1); cyc(10);
    for (int i = 0; i < NCH; i++) chk("test_edges_ge9", i, 16'(edges[i] - snap1[i] >= 9), 16'd1);
    chk("test_gated", 0, 16'(gated), 16'hF);
    chk("test_enable", 0, 16'(en), 16'h0);
    chk("test_all_gated", 0, 16'(all_g), 16'd1);

    test_en = 1'b0;
    cyc(1);
    take_snap(snap1); cyc(10);
    for (int i = 0; i < NCH; i++) chk("untest_edges", i, 16'(edges[i] - snap1[i]), 16'd0);

    // Reset, then ch0 idles to GATED: edges at posedges 1..5 only.
    foff = '0; busy = '1; rst = 1'b1;
    cyc(2);
    chk("rst_enable", 0, 16'(en), 16'hF);
    chk("rst_gated", 0, 16'(gated), 16'h0);
    rst = 1'b0; busy = 4'hE; thresh = 8'd4;
    take_snap(snap1); cyc(5);
    take_snap(snap2);
    chk("idle_edges_1to5", 0, 16'(snap2[0] - snap1[0]), 16'd5);
    chk("idle_gated_p5", 0, 16'(gated), 16'h1);
    cyc(5);
    chk("idle_edges_6to10", 0, 16'(edges[0] - snap2[0]), 16'd0);
    chk("busy_ch1_edges", 1, 16'(edges[1] - snap1[1]), 16'd10);

    // Wake then reset mid-WAKE: edge right after WAKE entry, no ack.
    req = 4'h1;
    cyc(1);
    chk("wake_enable", 0, 16'(en[0]), 16'd1);
    chk("wake_ack", 0, 16'(ack), 16'h0);
    rst = 1'b1; req = '0;
    take_snap(snap1); cyc(1);
    chk("wake_edge_k1", 0, 16'(edges[0] - snap1[0]), 16'd1);
    chk("rstwake_gated", 0, 16'(gated), 16'h0);
    chk("rstwake_ack", 0, 16'(ack), 16'h0);
    chk("rstwake_enable", 0, 16'(en), 16'hF);
    rst = 1'b0; busy = '1;
    take_snap(snap1); cyc(5);
    chk("rstwake_edges", 0, 16'(edges[0] - snap1[0]), 16'd5);

    chk("short_pulses", 0, 16'(short_pulses), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
